// File: rtl/binary_bbox_tracker_if.sv
// Pixel stream in, per-frame bounding-box results out, for binary_bbox_tracker.
// The master drives the pixel stream and the slave returns the frame results.
interface binary_bbox_tracker_if;
    logic        i_valid;
    logic        i_data;
    logic        i_sof;
    logic        o_frame_done;
    logic        o_found;
    logic [9:0]  o_x_min;
    logic [9:0]  o_x_max;
    logic [9:0]  o_y_min;
    logic [9:0]  o_y_max;
    logic [9:0]  o_x_ctr;
    logic [9:0]  o_y_ctr;
    logic [18:0] o_count;
    logic [7:0]  o_frame_cnt;

    modport master (
        output i_valid, i_data, i_sof,
        input  o_frame_done, o_found, o_x_min, o_x_max, o_y_min, o_y_max,
               o_x_ctr, o_y_ctr, o_count, o_frame_cnt
    );

    modport slave (
        input  i_valid, i_data, i_sof,
        output o_frame_done, o_found, o_x_min, o_x_max, o_y_min, o_y_max,
               o_x_ctr, o_y_ctr, o_count, o_frame_cnt
    );
endinterface

// File: rtl/binary_bbox_tracker.sv
// Tracks the bounding box, centre and pixel count of the foreground in a
// raster-ordered binary stream and publishes them once per frame.
module binary_bbox_tracker #(
    parameter int H_ACTIVE   = 800,
    parameter int V_ACTIVE   = 600,
    parameter int MIN_PIXELS = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    binary_bbox_tracker_if.slave  bus
);
    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    function automatic logic [9:0] f_min(input logic [9:0] a, input logic [9:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [9:0] f_max(input logic [9:0] a, input logic [9:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [9:0] f_ctr(input logic [9:0] a, input logic [9:0] b);
        logic [10:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[10:1];
    endfunction

    logic [9:0]  r_x, r_y;
    logic [9:0]  r_acc_xmin, r_acc_xmax, r_acc_ymin, r_acc_ymax;
    logic [18:0] r_acc_cnt;

    logic        r_frame_done, r_found;
    logic [9:0]  r_x_min, r_x_max, r_y_min, r_y_max, r_x_ctr, r_y_ctr;
    logic [18:0] r_count;
    logic [7:0]  r_frame_cnt;

    logic [9:0]  w_px, w_py, w_nx, w_ny;
    logic [9:0]  w_bxmin, w_bxmax, w_bymin, w_bymax;
    logic [9:0]  w_nxmin, w_nxmax, w_nymin, w_nymax;
    logic [18:0] w_bcnt, w_ncnt;
    logic        w_hit, w_eof, w_nfound;

    // A start-of-frame pulse makes the current cycle look like a fresh frame,
    // so a coincident valid pixel lands at (0,0) in clean accumulators.
    always_comb begin
        w_px    = bus.i_sof ? 10'd0    : r_x;
        w_py    = bus.i_sof ? 10'd0    : r_y;
        w_bxmin = bus.i_sof ? 10'h3FF  : r_acc_xmin;
        w_bxmax = bus.i_sof ? 10'd0    : r_acc_xmax;
        w_bymin = bus.i_sof ? 10'h3FF  : r_acc_ymin;
        w_bymax = bus.i_sof ? 10'd0    : r_acc_ymax;
        w_bcnt  = bus.i_sof ? 19'd0    : r_acc_cnt;
    end

    assign w_hit    = bus.i_valid & bus.i_data;
    assign w_nxmin  = w_hit ? f_min(w_bxmin, w_px) : w_bxmin;
    assign w_nxmax  = w_hit ? f_max(w_bxmax, w_px) : w_bxmax;
    assign w_nymin  = w_hit ? f_min(w_bymin, w_py) : w_bymin;
    assign w_nymax  = w_hit ? f_max(w_bymax, w_py) : w_bymax;
    assign w_ncnt   = w_bcnt + 19'(w_hit);
    assign w_nfound = (w_ncnt >= 19'(MIN_PIXELS));
    assign w_eof    = bus.i_valid & ~bus.i_sof & (r_x == X_LAST) & (r_y == Y_LAST);

    always_comb begin
        w_nx = w_px;
        w_ny = w_py;
        if (bus.i_valid) begin
            if (w_px == X_LAST) begin
                w_nx = 10'd0;
                w_ny = (w_py == Y_LAST) ? 10'd0 : w_py + 10'd1;
            end else begin
                w_nx = w_px + 10'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x          <= '0;
            r_y          <= '0;
            r_acc_xmin   <= '1;
            r_acc_xmax   <= '0;
            r_acc_ymin   <= '1;
            r_acc_ymax   <= '0;
            r_acc_cnt    <= '0;
            r_frame_done <= 1'b0;
            r_found      <= 1'b0;
            r_x_min      <= '0;
            r_x_max      <= '0;
            r_y_min      <= '0;
            r_y_max      <= '0;
            r_x_ctr      <= '0;
            r_y_ctr      <= '0;
            r_count      <= '0;
            r_frame_cnt  <= '0;
        end else begin
            r_x          <= w_nx;
            r_y          <= w_ny;
            r_frame_done <= w_eof;
            if (w_eof) begin
                r_acc_xmin  <= '1;
                r_acc_xmax  <= '0;
                r_acc_ymin  <= '1;
                r_acc_ymax  <= '0;
                r_acc_cnt   <= '0;
                r_count     <= w_ncnt;
                r_found     <= w_nfound;
                r_frame_cnt <= r_frame_cnt + 8'd1;
                // Below threshold the previous box is kept for the overlay.
                if (w_nfound) begin
                    r_x_min <= w_nxmin;
                    r_x_max <= w_nxmax;
                    r_y_min <= w_nymin;
                    r_y_max <= w_nymax;
                    r_x_ctr <= f_ctr(w_nxmin, w_nxmax);
                    r_y_ctr <= f_ctr(w_nymin, w_nymax);
                end
            end else begin
                r_acc_xmin <= w_nxmin;
                r_acc_xmax <= w_nxmax;
                r_acc_ymin <= w_nymin;
                r_acc_ymax <= w_nymax;
                r_acc_cnt  <= w_ncnt;
            end
        end
    end

    assign bus.o_frame_done = r_frame_done;
    assign bus.o_found      = r_found;
    assign bus.o_x_min      = r_x_min;
    assign bus.o_x_max      = r_x_max;
    assign bus.o_y_min      = r_y_min;
    assign bus.o_y_max      = r_y_max;
    assign bus.o_x_ctr      = r_x_ctr;
    assign bus.o_y_ctr      = r_y_ctr;
    assign bus.o_count      = r_count;
    assign bus.o_frame_cnt  = r_frame_cnt;
endmodule

// File: tb/tb_binary_bbox_tracker.sv
// Directed bench for binary_bbox_tracker on a reduced 16x12 frame; a second
// instance with MIN_PIXELS=2 shares the stimulus for the corner-pixel frame.
module tb_binary_bbox_tracker;
    localparam int H = 16;
    localparam int V = 12;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    int   pulses = 0;

    binary_bbox_tracker_if bus ();
    binary_bbox_tracker_if bus2 ();

    assign bus2.i_valid = bus.i_valid;
    assign bus2.i_data  = bus.i_data;
    assign bus2.i_sof   = bus.i_sof;

    binary_bbox_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(64)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus));
    binary_bbox_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_PIXELS(2)) dut2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(bus2));

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) if (bus.o_frame_done) pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Foreground patterns on the 16x12 frame.
    function automatic bit pix(input int p, input int x, input int y);
        case (p)
            1: return (x >= 2 && x <= 13 && y >= 1 && y <= 8);            // 96 px
            2: return (y >= 4 && y <= 7 && !(x == 15 && y == 7));          // 63 px
            3: return (y >= 4 && y <= 7);                                  // 64 px
            4: return ((x == 0 && y == 0) || (x == H-1 && y == V-1));      // 2 px
            5: return 1'b1;
            6: return ((x == 0 && y == 0) || (y >= 4 && y <= 7));          // 65 px
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge i_clk);
        #1;
    endtask

    task automatic px(input bit d, input bit s);
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        bus.i_sof   = s;
        @(posedge i_clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_data  = 1'b0;
        bus.i_sof   = 1'b0;
    endtask

    task automatic send(input int p, input int gap, input bit sof_first, input int nrows);
        for (int y = 0; y < nrows; y++)
            for (int x = 0; x < H; x++) begin
                while (gap > 0 && $urandom_range(0, 99) < gap) idle(1);
                px(pix(p, x, y), sof_first && x == 0 && y == 0);
            end
    endtask

    task automatic chk_frame(input string tag, input int p0, input bit f,
                             input int xmn, input int xmx, input int ymn, input int ymx,
                             input int xc, input int yc, input int cnt, input int fc);
        check({tag, ".done"},  bus.o_frame_done, 1);
        check({tag, ".found"}, bus.o_found, f);
        check({tag, ".xmin"},  bus.o_x_min, xmn);
        check({tag, ".xmax"},  bus.o_x_max, xmx);
        check({tag, ".ymin"},  bus.o_y_min, ymn);
        check({tag, ".ymax"},  bus.o_y_max, ymx);
        check({tag, ".xctr"},  bus.o_x_ctr, xc);
        check({tag, ".yctr"},  bus.o_y_ctr, yc);
        check({tag, ".count"}, bus.o_count, cnt);
        check({tag, ".fcnt"},  bus.o_frame_cnt, fc);
        idle(2);
        check({tag, ".pulses"}, pulses - p0, 1);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, ".done"},  bus.o_frame_done, 0);
        check({tag, ".found"}, bus.o_found, 0);
        check({tag, ".xmin"},  bus.o_x_min, 0);
        check({tag, ".xmax"},  bus.o_x_max, 0);
        check({tag, ".ymin"},  bus.o_y_min, 0);
        check({tag, ".ymax"},  bus.o_y_max, 0);
        check({tag, ".xctr"},  bus.o_x_ctr, 0);
        check({tag, ".yctr"},  bus.o_y_ctr, 0);
        check({tag, ".count"}, bus.o_count, 0);
        check({tag, ".fcnt"},  bus.o_frame_cnt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        bus.i_valid = 1'b0;
        bus.i_data  = 1'b0;
        bus.i_sof   = 1'b0;
        #22;
        chk_zero("reset");
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        idle(2);

        p0 = pulses; send(0, 0, 0, V);
        chk_frame("empty", p0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        p0 = pulses; send(1, 0, 0, V);
        chk_frame("block", p0, 1, 2, 13, 1, 8, 7, 4, 96, 2);

        p0 = pulses; send(2, 0, 0, V);
        chk_frame("thr63", p0, 0, 2, 13, 1, 8, 7, 4, 63, 3);

        p0 = pulses; send(3, 0, 0, V);
        chk_frame("thr64", p0, 1, 0, 15, 4, 7, 7, 5, 64, 4);

        p0 = pulses; send(4, 0, 0, V);
        check("corner2.found", bus2.o_found, 1);
        check("corner2.xmin",  bus2.o_x_min, 0);
        check("corner2.xmax",  bus2.o_x_max, 15);
        check("corner2.ymin",  bus2.o_y_min, 0);
        check("corner2.ymax",  bus2.o_y_max, 11);
        check("corner2.xctr",  bus2.o_x_ctr, 7);
        check("corner2.yctr",  bus2.o_y_ctr, 5);
        check("corner2.count", bus2.o_count, 2);
        chk_frame("corner", p0, 0, 0, 15, 4, 7, 7, 5, 2, 5);

        p0 = pulses; send(1, 70, 0, V);
        chk_frame("gaps", p0, 1, 2, 13, 1, 8, 7, 4, 96, 6);

        p0 = pulses; send(5, 0, 0, 6);
        idle(2);
        check("sofpart.pulses", pulses - p0, 0);
        p0 = pulses; send(6, 0, 1, V);
        chk_frame("sof", p0, 1, 0, 15, 0, 7, 7, 3, 65, 7);

        send(5, 0, 0, 3);
        #3 i_rst_n = 1'b0;
        #1 chk_zero("rstmid");
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        idle(1);
        p0 = pulses; send(1, 0, 0, V);
        chk_frame("postrst", p0, 1, 2, 13, 1, 8, 7, 4, 96, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/binary_bbox_tracker.md
# binary_bbox_tracker

Consumes the 1-bit cleaned foreground stream from the 3x3 median filter stage and measures the single object in each 800x600 frame. Per frame it tracks the bounding box (min/max column and row) of all foreground pixels and the foreground pixel count. At frame end it publishes the box, its centre and a found flag to the overlay/control logic downstream. Internal raster counters track position, with an optional start-of-frame resync.

## Interface
- H_ACTIVE, 800, valid pixels per row
- V_ACTIVE, 600, rows per frame
- MIN_PIXELS, 64, minimum foreground count for a frame to report an object
- i_clk  in  1  pixel clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_valid  in  1  pixel strobe; one pixel per asserted cycle, raster order
- i_data  in  1  pixel value, 1 = foreground
- i_sof  in  1  optional start-of-frame pulse; tie 0 if unused
- o_frame_done  out  1  one-cycle pulse, results updated
- o_found  out  1  last frame had count >= MIN_PIXELS
- o_x_min, o_x_max  out  10  bounding-box columns
- o_y_min, o_y_max  out  10  bounding-box rows
- o_x_ctr, o_y_ctr  out  10  box centre, (min+max)>>1
- o_count  out  19  foreground pixels in last frame
- o_frame_cnt  out  8  completed frames, wraps 255->0

## Operation
- Raster counters x (0..H_ACTIVE-1) and y (0..V_ACTIVE-1) advance only on i_valid. x wraps to 0 and y increments at x==H_ACTIVE-1. The current pixel's coordinate is (x,y) before the increment.
- Accumulators: acc_xmin/acc_ymin init to all-ones (1023); acc_xmax/acc_ymax init to 0; acc_cnt init to 0.
- On i_valid && i_data: acc_cnt+1; acc_xmin=min(acc_xmin,x); acc_xmax=max(acc_xmax,x); acc_ymin=min(acc_ymin,y); acc_ymax=max(acc_ymax,y).
- Last pixel is i_valid with x==H_ACTIVE-1 and y==V_ACTIVE-1. On the last pixel, results are computed from the accumulators *including* that pixel's contribution, using combinational next values.
- At frame end:
  - o_count <= final count, always.
  - o_found <= (final count >= MIN_PIXELS).
  - If found: the box and centre outputs load the final values, and the centre uses an 11-bit sum before >>1.
  - If not found: box and centre outputs hold the previous frame's values.
  - o_frame_cnt increments.
  - x, y and all accumulators return to their init values.
- i_sof: clears x, y and accumulators, discarding the partial frame with no o_frame_done.
  - If i_sof and i_valid occur in the same cycle, the pixel is treated as (0,0) of the new frame and accumulated into freshly initialised accumulators.
  - i_sof coincident with the last pixel: i_sof wins, no frame completion.
- i_valid gaps of any length are allowed and freeze all state.
- acc_cnt cannot overflow: max is 480000 < 2^19.

## Timing
- Reset: all outputs 0 (o_frame_done=0, o_found=0, box/centre 0, o_count 0, o_frame_cnt 0). x=y=0 and accumulators at init values.
- Reset mid-frame discards the partial frame. The first frame after reset is counted from the next valid pixel.
- Latency: o_frame_done is high exactly one cycle, in the cycle after the last pixel is sampled. All result outputs are valid and stable from that same cycle until the next o_frame_done.
- All outputs are registered; there is no combinational path from inputs to outputs.
- A pixel arriving in the o_frame_done cycle belongs to the next frame at (0,0).

## Test plan
- **Empty frame:** 480000 pixels all 0 -> one o_frame_done pulse; o_found=0, o_count=0, box holds reset values 0, o_frame_cnt=1.
- **Single block:** foreground at columns 100..199, rows 50..149 (10000 px) -> o_found=1, x 100/199, y 50/149, ctr (149,99), o_count=10000.
- **Threshold edge:** frame with 63 foreground px -> o_found=0 and the previous box is held. Then a frame with exactly 64 px -> o_found=1 and the box updates.
- **Corner pixels:** foreground only at (0,0) and at (799,599), the final pixel, with MIN_PIXELS overridden to 2 -> x 0/799, y 0/599, ctr (399,299), o_count=2. The last pixel must be included.
- **Gaps and resync:**
  - Random i_valid duty (~30%) -> results are identical to the gap-free run.
  - i_sof mid-frame at row 300 -> no o_frame_done; the next full frame reports only its own pixels.
  - i_sof+i_valid with i_data=1 -> that pixel is counted at (0,0).
- **Async reset mid-frame:** assert i_rst_n low at row 200 -> all outputs 0 immediately. Then a clean frame gives correct results and o_frame_cnt=1.
